// File: rtl/sc_phase_pkg.sv
// Shared types and constants for the two-phase non-overlapping clock generator.
// Holds the FSM state encoding, the runtime configuration record and the
// phase-length clamp helper. The config record widths set the default build
// of sc_nonoverlap_phase_gen (4 channels, 8-bit phase field, 4-bit dead field).
package sc_phase_pkg;

    localparam int N_CH_C        = 4;
    localparam int CNT_W_C       = 8;
    localparam int DEAD_W_C      = 4;
    localparam int EARLY_C       = 1;
    localparam int DEF_PHASE_LEN = 15;
    // dead time is dead_len+1 cycles, so the shortest gap between phases is one cycle
    localparam int MIN_DEAD_CYC  = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        D12  = 3'd2,
        P2   = 3'd3,
        D21  = 3'd4
    } sc_state_t;

    typedef struct packed {
        logic [CNT_W_C-1:0]  phase_len;
        logic [DEAD_W_C-1:0] dead_len;
        logic [N_CH_C-1:0]   ch_mask;
    } sc_cfg_t;

    // A phase must be long enough to hold the whole early-fall window, so the
    // requested length is raised to the early length when it is shorter.
    function automatic logic [CNT_W_C-1:0] clamp_phase(
        input logic [CNT_W_C-1:0] req,
        input logic [CNT_W_C-1:0] floor_v
    );
        logic [CNT_W_C-1:0] res;
        if (req < floor_v) begin
            res = floor_v;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_phase_cfg_shadow.sv
// Configuration shadow register for the phase generator.
// A valid/ready handshake captures one config into the shadow (phase length
// clamped on the way in) and drops cfg_ready. The shadow is copied into the
// active config only when the FSM reports a legal apply point (period
// boundary, or any cycle in IDLE); cfg_ready rises the cycle after the copy.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_valid           config offer
//   cfg_phase_len/dead_len/ch_mask  offered config fields
//   apply_ok            FSM is at a point where the shadow may become active
//   cfg_ready           shadow empty, next offer will be taken
//   act_next            active config as it will be after this clock edge
module sc_phase_cfg_shadow
    import sc_phase_pkg::*;
#(
    parameter int EARLY     = EARLY_C,
    parameter int DEF_PHASE = DEF_PHASE_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    input  logic [CNT_W_C-1:0]  cfg_phase_len,
    input  logic [DEAD_W_C-1:0] cfg_dead_len,
    input  logic [N_CH_C-1:0]   cfg_ch_mask,
    input  logic                apply_ok,
    output logic                cfg_ready,
    output sc_cfg_t             act_next
);

    localparam logic [CNT_W_C-1:0] EARLY_V = CNT_W_C'(EARLY);
    localparam sc_cfg_t RST_CFG = sc_cfg_t'({CNT_W_C'(DEF_PHASE), {DEAD_W_C{1'b0}}, {N_CH_C{1'b1}}});

    sc_cfg_t shadow_r;
    sc_cfg_t active_r;
    sc_cfg_t load_s;
    logic    ready_r;
    logic    accept_s;
    logic    apply_s;

    // Handshake decode, clamped shadow load value and the active config seen by the FSM.
    always_comb begin
        accept_s         = 1'b0;
        apply_s          = 1'b0;
        load_s           = shadow_r;
        act_next         = active_r;
        accept_s         = cfg_valid && ready_r;
        // a full shadow is the only thing that can be applied
        apply_s          = (!ready_r) && apply_ok;
        load_s.phase_len = clamp_phase(cfg_phase_len, EARLY_V);
        load_s.dead_len  = cfg_dead_len;
        load_s.ch_mask   = cfg_ch_mask;
        if (apply_s) begin
            act_next = shadow_r;
        end else begin
            act_next = active_r;
        end
    end

    // Shadow, active config and ready flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= RST_CFG;
            active_r <= RST_CFG;
            ready_r  <= 1'b1;
        end else begin
            active_r <= act_next;
            if (accept_s) begin
                shadow_r <= load_s;
                ready_r  <= 1'b0;
            end else if (apply_s) begin
                ready_r  <= 1'b1;
            end else begin
                ready_r  <= ready_r;
            end
        end
    end

    assign cfg_ready = ready_r;

endmodule

// File: rtl/sc_nonoverlap_phase_gen.sv
// Two-phase non-overlapping clock generator for switched-capacitor filter banks.
// Sequence IDLE -> P1 -> D12 -> P2 -> D21 -> (P1 while en, else IDLE). A single
// down-counter is reloaded on every state entry and the state is left when it
// reaches zero, so each phase lasts phase_len+1 cycles and each dead time
// dead_len+1 cycles. Every output is a flop fed from the next-state decode, so
// the outputs line up exactly with the registered state and cannot glitch.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   en                    run request, sampled in IDLE and on the last D21 cycle
//   cfg_valid/cfg_ready   config handshake into the shadow register
//   cfg_phase_len         phase high time = value+1 cycles (clamped to >= EARLY)
//   cfg_dead_len          dead time = value+1 cycles
//   cfg_ch_mask           per-channel enable; masked channels stay low
//   phi1, phi2            main phases per channel
//   phi1e, phi2e          early phases, fall EARLY cycles before phi1/phi2
//   period_done           pulse on the last cycle of every period
//   busy                  high whenever the FSM is not IDLE
module sc_nonoverlap_phase_gen
    import sc_phase_pkg::*;
#(
    parameter int N_CH      = N_CH_C,
    parameter int CNT_W     = CNT_W_C,
    parameter int DEAD_W    = DEAD_W_C,
    parameter int EARLY     = EARLY_C,
    parameter int DEF_PHASE = DEF_PHASE_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_phase_len,
    input  logic [DEAD_W-1:0] cfg_dead_len,
    input  logic [N_CH-1:0]   cfg_ch_mask,
    output logic [N_CH-1:0]   phi1,
    output logic [N_CH-1:0]   phi2,
    output logic [N_CH-1:0]   phi1e,
    output logic [N_CH-1:0]   phi2e,
    output logic              period_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] EARLY_V  = CNT_W'(EARLY);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [N_CH-1:0]  CH_ZERO  = {N_CH{1'b0}};

    sc_state_t         state_r;
    sc_state_t         state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_n_s;
    logic [CNT_W-1:0]  dead_ext_s;
    logic              apply_ok_s;
    logic              entry_s;
    sc_cfg_t           act_cfg_s;
    logic [N_CH-1:0]   phi1_n_s;
    logic [N_CH-1:0]   phi2_n_s;
    logic [N_CH-1:0]   phi1e_n_s;
    logic [N_CH-1:0]   phi2e_n_s;
    logic              done_n_s;
    logic              busy_n_s;

    sc_phase_cfg_shadow #(
        .EARLY     (EARLY),
        .DEF_PHASE (DEF_PHASE)
    ) u_cfg_shadow (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_phase_len (cfg_phase_len),
        .cfg_dead_len  (cfg_dead_len),
        .cfg_ch_mask   (cfg_ch_mask),
        .apply_ok      (apply_ok_s),
        .cfg_ready     (cfg_ready),
        .act_next      (act_cfg_s)
    );

    // Next-state decode and the period-boundary / idle apply window for the shadow.
    always_comb begin
        state_n_s  = state_r;
        apply_ok_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) state_n_s = P1;
                else    state_n_s = IDLE;
            end
            P1: begin
                if (cnt_r == CNT_ZERO) state_n_s = D12;
                else                   state_n_s = P1;
            end
            D12: begin
                if (cnt_r == CNT_ZERO) state_n_s = P2;
                else                   state_n_s = D12;
            end
            P2: begin
                if (cnt_r == CNT_ZERO) state_n_s = D21;
                else                   state_n_s = P2;
            end
            D21: begin
                // en is only looked at here, so a period always runs to completion
                if (cnt_r != CNT_ZERO) state_n_s = D21;
                else if (en)           state_n_s = P1;
                else                   state_n_s = IDLE;
            end
            default: state_n_s = IDLE;
        endcase
        apply_ok_s = (state_r == IDLE) || ((state_r == D21) && (state_n_s == P1));
    end

    // Counter reload/decrement and next-cycle output decode.
    always_comb begin
        cnt_n_s    = cnt_r;
        dead_ext_s = {{(CNT_W-DEAD_W){1'b0}}, act_cfg_s.dead_len};
        entry_s    = (state_n_s != state_r);
        phi1_n_s   = CH_ZERO;
        phi2_n_s   = CH_ZERO;
        phi1e_n_s  = CH_ZERO;
        phi2e_n_s  = CH_ZERO;
        done_n_s   = 1'b0;
        busy_n_s   = 1'b0;
        case (state_n_s)
            P1, P2: begin
                if (entry_s) cnt_n_s = act_cfg_s.phase_len;
                else         cnt_n_s = cnt_r - CNT_W'(1);
            end
            D12, D21: begin
                if (entry_s) cnt_n_s = dead_ext_s;
                else         cnt_n_s = cnt_r - CNT_W'(1);
            end
            default: cnt_n_s = CNT_ZERO;
        endcase
        // early phase is dropped for the last EARLY counts of its phase
        if (state_n_s == P1) begin
            phi1_n_s = act_cfg_s.ch_mask;
            if (cnt_n_s >= EARLY_V) phi1e_n_s = act_cfg_s.ch_mask;
            else                    phi1e_n_s = CH_ZERO;
        end else begin
            phi1_n_s  = CH_ZERO;
            phi1e_n_s = CH_ZERO;
        end
        if (state_n_s == P2) begin
            phi2_n_s = act_cfg_s.ch_mask;
            if (cnt_n_s >= EARLY_V) phi2e_n_s = act_cfg_s.ch_mask;
            else                    phi2e_n_s = CH_ZERO;
        end else begin
            phi2_n_s  = CH_ZERO;
            phi2e_n_s = CH_ZERO;
        end
        done_n_s = (state_n_s == D21) && (cnt_n_s == CNT_ZERO);
        busy_n_s = (state_n_s != IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            phi1        <= CH_ZERO;
            phi2        <= CH_ZERO;
            phi1e       <= CH_ZERO;
            phi2e       <= CH_ZERO;
            period_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            phi1        <= phi1_n_s;
            phi2        <= phi2_n_s;
            phi1e       <= phi1e_n_s;
            phi2e       <= phi2e_n_s;
            period_done <= done_n_s;
            busy        <= busy_n_s;
        end
    end

endmodule

// File: tb/tb_sc_nonoverlap_phase_gen.sv
// Self-checking bench for sc_nonoverlap_phase_gen: directed scenarios checked
// against period-position arithmetic, then randomized en/cfg/rst checked
// against a period-queue reference model.
module tb_sc_nonoverlap_phase_gen;

    localparam int EARLY = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_phase_len;
    logic [3:0] cfg_dead_len;
    logic [3:0] cfg_ch_mask;
    logic [3:0] phi1, phi2, phi1e, phi2e;
    logic       period_done;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    sc_nonoverlap_phase_gen dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_phase_len (cfg_phase_len),
        .cfg_dead_len  (cfg_dead_len),
        .cfg_ch_mask   (cfg_ch_mask),
        .phi1          (phi1),
        .phi2          (phi2),
        .phi1e         (phi1e),
        .phi2e         (phi2e),
        .period_done   (period_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Expected {phi1,phi1e,phi2,phi2e,period_done} at position pos of a period
    // built from phase length pl, dead length dl and mask.
    function automatic logic [16:0] exp_vec(input int pos, input int pl, input int dl,
                                            input logic [3:0] mask);
        int per, p, s2;
        logic [3:0] a, ae, b, be;
        logic d;
        a = 4'h0; ae = 4'h0; b = 4'h0; be = 4'h0;
        per = 2 * (pl + 1) + 2 * (dl + 1);
        p   = pos % per;
        s2  = pl + dl + 2;
        if (p <= pl) begin
            a = mask;
            if (pl - p >= EARLY) ae = mask;
        end else if (p >= s2 && p <= s2 + pl) begin
            b = mask;
            if (pl - (p - s2) >= EARLY) be = mask;
        end
        d = (p == per - 1);
        return {a, ae, b, be, d};
    endfunction

    // ---------------- reference model (period queue) ----------------
    logic [16:0] mq[$];
    int          m_pl = 15, m_dl = 0, s_pl = 0, s_dl = 0;
    logic [3:0]  m_mask = 4'hF, s_mask = 4'h0;
    bit          m_pend = 1'b0;

    function automatic void push_period();
        int per;
        per = 2 * (m_pl + 1) + 2 * (m_dl + 1);
        for (int i = 0; i < per; i++) mq.push_back(exp_vec(i, m_pl, m_dl, m_mask));
    endfunction

    function automatic void apply_shadow();
        m_pl = s_pl; m_dl = s_dl; m_mask = s_mask; m_pend = 1'b0;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            mq.delete();
            m_pend = 1'b0; m_pl = 15; m_dl = 0; m_mask = 4'hF;
        end else begin
            acc = cfg_valid && !m_pend;
            if (mq.size() == 0) begin
                if (m_pend) apply_shadow();
                if (en) push_period();
            end else if (mq.size() == 1) begin
                void'(mq.pop_front());
                if (en) begin
                    if (m_pend) apply_shadow();
                    push_period();
                end
            end else begin
                void'(mq.pop_front());
            end
            if (acc) begin
                s_pl   = (int'(cfg_phase_len) < EARLY) ? EARLY : int'(cfg_phase_len);
                s_dl   = int'(cfg_dead_len);
                s_mask = cfg_ch_mask;
                m_pend = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready} !== 19'h1) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready}, 19'h1);
        end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready} !== 19'h1) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h want %h", {phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready}, 19'h1);
        end
    endtask

    task automatic test_default_period();
        logic [16:0] ev;
        en = 1'b1;
        tick();
        for (int k = 0; k < 68; k++) begin
            ev = exp_vec(k, 15, 0, 4'hF);
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done} !== ev) begin
                n_fail++;
                $display("FAIL default_period pos %0d: got %h want %h", k, {phi1, phi1e, phi2, phi2e, period_done}, ev);
            end
            tick();
        end
    endtask

    task automatic test_cfg_midperiod();
        int run, guard;
        logic [16:0] ev;
        guard = 0;
        while (phi2 == 4'h0 && guard < 40) begin tick(); guard++; end
        run = 0;
        repeat (3) begin
            if (phi2 != 4'h0) run++;
            tick();
        end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_ready_before_offer: got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1; cfg_phase_len = 8'd3; cfg_dead_len = 4'd2; cfg_ch_mask = 4'b0101;
        if (phi2 != 4'h0) run++;
        tick();
        cfg_valid = 1'b0;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_ready_after_accept: got %b want 0", cfg_ready);
        end
        guard = 0;
        while (phi2 != 4'h0 && guard < 40) begin run++; tick(); guard++; end
        n_cmp++;
        if (run != 16) begin
            n_fail++;
            $display("FAIL old_phi2_len: got %0d want 16", run);
        end
        guard = 0;
        while (period_done !== 1'b1 && guard < 40) begin tick(); guard++; end
        n_cmp++;
        if (period_done !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL old_period_end: got done=%b ready=%b want done=1 ready=0", period_done, cfg_ready);
        end
        tick();
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_ready_after_boundary: got %b want 1", cfg_ready);
        end
        for (int k = 0; k < 28; k++) begin
            ev = exp_vec(k, 3, 2, 4'b0101);
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done} !== ev) begin
                n_fail++;
                $display("FAIL new_cfg_period pos %0d: got %h want %h", k, {phi1, phi1e, phi2, phi2e, period_done}, ev);
            end
            tick();
        end
    endtask

    task automatic test_en_drop();
        int dones;
        logic [16:0] ev;
        tick();
        en = 1'b0;
        dones = 0;
        for (int k = 1; k < 14; k++) begin
            ev = exp_vec(k, 3, 2, 4'b0101);
            if (period_done === 1'b1) dones++;
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done, busy} !== {ev, 1'b1}) begin
                n_fail++;
                $display("FAIL en_drop_tail pos %0d: got %h want %h", k, {phi1, phi1e, phi2, phi2e, period_done, busy}, {ev, 1'b1});
            end
            tick();
        end
        repeat (3) begin
            if (period_done === 1'b1) dones++;
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done, busy} !== 18'h0) begin
                n_fail++;
                $display("FAIL en_drop_idle: got %h want 0", {phi1, phi1e, phi2, phi2e, period_done, busy});
            end
            tick();
        end
        n_cmp++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL en_drop_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_clamp();
        logic [16:0] ev;
        cfg_valid = 1'b1; cfg_phase_len = 8'd0; cfg_dead_len = 4'd0; cfg_ch_mask = 4'hF;
        tick();
        cfg_valid = 1'b0;
        tick();
        n_cmp++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_apply: got ready=%b busy=%b want ready=1 busy=0", cfg_ready, busy);
        end
        en = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            ev = exp_vec(k, 1, 0, 4'hF);
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done} !== ev) begin
                n_fail++;
                $display("FAIL clamp_period pos %0d: got %h want %h", k, {phi1, phi1e, phi2, phi2e, period_done}, ev);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int guard;
        logic [16:0] ev;
        guard = 0;
        while (phi2 == 4'h0 && guard < 20) begin tick(); guard++; end
        n_cmp++;
        if (phi2 !== 4'hF) begin
            n_fail++;
            $display("FAIL reach_p2: got %h want f", phi2);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready} !== 19'h1) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", {phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready}, 19'h1);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 34; k++) begin
            ev = exp_vec(k, 15, 0, 4'hF);
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done, cfg_ready} !== {ev, 1'b1}) begin
                n_fail++;
                $display("FAIL post_reset_defaults pos %0d: got %h want %h", k, {phi1, phi1e, phi2, phi2e, period_done, cfg_ready}, {ev, 1'b1});
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [16:0] ev;
        logic        eb, er;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) en = ~en;
            cfg_valid     = ($urandom_range(0, 3) == 0);
            cfg_phase_len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
            cfg_dead_len  = 4'($urandom);
            cfg_ch_mask   = 4'($urandom);
            rst           = ($urandom_range(0, 599) == 0);
            @(posedge clk);
            #1;
            if (mq.size() == 0) begin ev = 17'h0; eb = 1'b0; end
            else                begin ev = mq[0]; eb = 1'b1; end
            er = !m_pend;
            n_cmp++;
            if ({phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready} !== {ev, eb, er}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", c, {phi1, phi1e, phi2, phi2e, period_done, busy, cfg_ready}, {ev, eb, er});
            end
            n_cmp++;
            if (((phi1 & phi2) | (phi1e & phi2e) | (phi1e & ~phi1) | (phi2e & ~phi2)) !== 4'h0) begin
                n_fail++;
                $display("FAIL invariant cycle %0d: phi1=%h phi2=%h phi1e=%h phi2e=%h", c, phi1, phi2, phi1e, phi2e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        cfg_phase_len = 8'd0; cfg_dead_len = 4'd0; cfg_ch_mask = 4'h0;
        repeat (3) tick();
        test_reset();
        test_default_period();
        test_cfg_midperiod();
        test_en_drop();
        test_clamp();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
